// File: rtl/spi_ram.sv
// Command-driven single-port RAM that sits behind the SPI slave: address/data commands in, read data out.
// Optional build macro SPI_RAM_AUTO_INC_EN: post-increments the write/read pointers after each data access.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  // state   | meaning
  // IDLE    | no read data pending for the slave
  // TX_HOLD | tx_data holds read data; slave may still be shifting it out
  typedef enum logic {
    IDLE    = 1'b0,
    TX_HOLD = 1'b1
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  state_t                 state_q, state_d;
  logic                   rx_valid_q;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   mem_we;
  logic                   accept;
  logic [1:0]             opcode;
  logic [7:0]             payload;
  logic [ADDR_SIZE-1:0]   payload_addr;

  logic [7:0] mem [MEM_DEPTH];

  assign opcode       = rx_data[9:8];
  assign payload      = rx_data[7:0];
  assign payload_addr = rx_data[ADDR_SIZE-1:0];
  // A held rx_valid level counts once: only its rising edge is a command.
  assign accept       = rx_valid & ~rx_valid_q;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    tx_data_d = tx_data_q;
    mem_we    = 1'b0;
    if (accept) begin
      unique case (opcode)
        OP_WR_ADDR: begin
          wr_addr_d = payload_addr;
          state_d   = IDLE;
        end
        OP_WR_DATA: begin
          mem_we  = 1'b1;
          state_d = IDLE;
`ifdef SPI_RAM_AUTO_INC_EN
          wr_addr_d = wr_addr_q + 1'b1;
`endif
        end
        OP_RD_ADDR: begin
          rd_addr_d = payload_addr;
          state_d   = IDLE;
        end
        OP_RD_DATA: begin
          tx_data_d = mem[rd_addr_q];
          state_d   = TX_HOLD;
`ifdef SPI_RAM_AUTO_INC_EN
          rd_addr_d = rd_addr_q + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Array is deliberately left out of reset so it maps onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= payload;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == TX_HOLD);

endmodule

// File: tb/tb_spi_ram.sv
// Randomized self-checking bench for spi_ram against a command-level reference model.
module tb_spi_ram;

  logic       clk;
  logic       reset_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_mem [256];
  logic [7:0] m_wr, m_rd, m_txd;
  logic       m_txv;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr  = 8'h00;
    m_rd  = 8'h00;
    m_txd = 8'h00;
    m_txv = 1'b0;
  endtask

  task automatic model_accept(input logic [9:0] cmd);
    logic [7:0] p;
    p = cmd[7:0];
    case (cmd[9:8])
      2'd0: begin m_wr = p; m_txv = 1'b0; end
      2'd1: begin
        m_mem[m_wr] = p;
        m_txv = 1'b0;
`ifdef SPI_RAM_AUTO_INC_EN
        m_wr = m_wr + 8'd1;
`endif
      end
      2'd2: begin m_rd = p; m_txv = 1'b0; end
      default: begin
        m_txd = m_mem[m_rd];
        m_txv = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
        m_rd = m_rd + 8'd1;
`endif
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, {31'd0, m_txv});
    check({tag, "_tx_data"}, {24'd0, tx_data}, {24'd0, m_txd});
  endtask

  // Raise rx_valid for 'hold' cycles, then keep it low for 'gap' cycles.
  task automatic send(input logic [9:0] cmd, input int hold, input int gap);
    @(negedge clk);
    rx_data  = cmd;
    rx_valid = 1'b1;
    model_accept(cmd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_outputs("held");
    end
    rx_valid = 1'b0;
    rx_data  = 10'($urandom);
    for (int i = 1; i < gap; i++) @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 10'h000;
    model_reset();
    #7;
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // fill the array so every later read has a defined expectation
    for (int a = 0; a < 256; a++) begin
      send({2'b00, 8'(a)}, 1, 1);
      send({2'b01, 8'($urandom)}, 1, 1);
    end

    // write then read back
    send(10'h012, 1, 1);
    send(10'h1A5, 1, 1);
    send(10'h212, 1, 1);
    send(10'h3C7, 1, 1);
    check("wr_rd_data", {24'd0, tx_data}, 32'hA5);
    check("wr_rd_valid", {31'd0, tx_valid}, 32'd1);

    // any non-read command releases tx_valid, data holds
    send(10'h000, 1, 1);
    check("release_valid", {31'd0, tx_valid}, 32'd0);
    check("release_data", {24'd0, tx_data}, 32'hA5);

    // held level is a single command
    send(10'h020, 1, 1);
    send(10'h13C, 5, 1);
    send(10'h155, 3, 1);
    send(10'h220, 1, 1);
    send(10'h300, 1, 1);
`ifdef SPI_RAM_AUTO_INC_EN
    check("held_write", {24'd0, tx_data}, 32'h3C);
    send(10'h300, 1, 1);
    check("held_single_inc", {24'd0, tx_data}, 32'h55);
`else
    check("held_write", {24'd0, tx_data}, 32'h55);
`endif

`ifdef SPI_RAM_AUTO_INC_EN
    // pointer wrap
    send(10'h0FF, 1, 1);
    send(10'h111, 1, 1);
    send(10'h122, 1, 1);
    send(10'h2FF, 1, 1);
    send(10'h300, 1, 1);
    check("wrap_rd0", {24'd0, tx_data}, 32'h11);
    send(10'h300, 1, 1);
    check("wrap_rd1", {24'd0, tx_data}, 32'h22);
    check("wrap_valid", {31'd0, tx_valid}, 32'd1);
`else
    // back-to-back reads
    send(10'h212, 1, 1);
    send(10'h300, 1, 1);
    check("b2b_rd0", {24'd0, tx_data}, 32'hA5);
    send(10'h3FF, 2, 1);
    check("b2b_rd1", {24'd0, tx_data}, 32'hA5);
    check("b2b_valid", {31'd0, tx_valid}, 32'd1);
`endif

    // async reset in TX_HOLD, with rx_valid already high at release
    send(10'h300, 1, 1);
    check("pre_reset_valid", {31'd0, tx_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("async_rst_data", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    model_accept(10'h300);
    @(negedge clk);
    check_outputs("rst_release_accept");
    rx_valid = 1'b0;
    // write pointer must also be back at 0 (or 1 with auto increment from the read above is rd only)
    send(10'h15A, 1, 1);
    send(10'h200, 1, 1);
    send(10'h300, 1, 1);
    check_outputs("rst_wr_ptr");

    // randomized traffic, including one-cycle toggling
    for (int k = 0; k < 400; k++) begin
      logic [9:0] c;
      c = 10'($urandom);
      send(c, $urandom_range(1, 4), $urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
